// File: rtl/uart_frame_writer.sv
// Parses HDR/LEN/payload/CHK byte frames from a UART receiver and streams the
// payload into a RAM through a wrapping write pointer, rolling back bad frames.
module uart_frame_writer #(
  parameter logic [7:0]  HDR         = 8'hA5,
  parameter int          ADDR_W      = 15,
  parameter logic [23:0] TIMEOUT_CYC = 24'd500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [1:0] {IDLE, GET_LEN, GET_DATA, GET_CHK} state_t;

  state_t            state, state_nxt;
  logic [7:0]        remain;
  logic [7:0]        acc;
  logic [ADDR_W-1:0] ptr, ptr_nxt, frame_base;
  logic [23:0]       tcnt;

  logic do_write, do_done, do_err, restore, save_base, load_len, timeout;

  // A byte arriving on the expiry cycle suppresses the timeout.
  assign timeout = (state != IDLE) && !rx_valid && (tcnt == TIMEOUT_CYC - 24'd1);
  assign busy    = (state != IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    state_nxt = state;
    do_write  = 1'b0;
    do_done   = 1'b0;
    do_err    = 1'b0;
    restore   = 1'b0;
    save_base = 1'b0;
    load_len  = 1'b0;
    case (state)
      IDLE: if (rx_valid && rx_data == HDR) begin
        state_nxt = GET_LEN;
        save_base = 1'b1;
      end
      GET_LEN: if (rx_valid) begin
        if (rx_data == 8'd0) begin
          do_err    = 1'b1;
          state_nxt = IDLE;
        end else begin
          load_len  = 1'b1;
          state_nxt = GET_DATA;
        end
      end
      GET_DATA: if (rx_valid) begin
        do_write = 1'b1;
        if (remain == 8'd1) state_nxt = GET_CHK;
      end
      GET_CHK: if (rx_valid) begin
        if (rx_data == acc) begin
          do_done = 1'b1;
        end else begin
          do_err  = 1'b1;
          restore = 1'b1;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (timeout) begin
      state_nxt = IDLE;
      do_err    = 1'b1;
      restore   = 1'b1;
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    if (restore)       ptr_nxt = frame_base;
    else if (do_write) ptr_nxt = ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      frame_base <= '0;
      remain     <= '0;
      acc        <= '0;
      tcnt       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      wr_en      <= do_write;
      // Outside write strobes wr_addr tracks the next free location.
      wr_addr    <= do_write ? ptr : ptr_nxt;
      frame_done <= do_done;
      frame_err  <= do_err;
      tcnt       <= (state == IDLE || rx_valid) ? 24'd0 : tcnt + 24'd1;
      if (do_write) begin
        wr_data <= rx_data;
        remain  <= remain - 8'd1;
        acc     <= acc + rx_data;
      end
      if (load_len) begin
        remain <= rx_data;
        acc    <= 8'd0;
      end
      if (save_base) frame_base <= ptr;
      if (do_done)   frame_cnt  <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_frame_writer.sv
// Directed bench for uart_frame_writer: byte-per-cycle vector table plus
// hand sequences for timeout, pointer wrap and mid-frame reset.
module tb_uart_frame_writer;

  localparam int          AW = 15;
  localparam logic [23:0] T  = 24'd20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          frame_done, frame_err, busy;
  logic [15:0]   frame_cnt;

  int total = 0;
  int bad   = 0;

  uart_frame_writer #(.HDR(8'hA5), .ADDR_W(AW), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .frame_err(frame_err), .busy(busy),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        we;
    logic [14:0] addr;
    logic [7:0]  data;
    logic        done;
    logic        err;
    logic        bsy;
    logic [15:0] cnt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of input, then sample outputs just after the edge.
  task automatic step(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic check_outs(input string tag, input vec_t e);
    check({tag, ".wr_en"}, wr_en, e.we);
    check({tag, ".wr_addr"}, wr_addr, e.addr);
    if (e.we) check({tag, ".wr_data"}, wr_data, e.data);
    check({tag, ".done"}, frame_done, e.done);
    check({tag, ".err"}, frame_err, e.err);
    check({tag, ".busy"}, busy, e.bsy);
    check({tag, ".cnt"}, frame_cnt, e.cnt);
  endtask

  vec_t vecs[$];
  vec_t e;

  initial begin
    // {v, d, we, addr, data, done, err, busy, cnt}
    vecs = '{
      // good frame A5 03 10 20 30 60
      '{1, 8'hA5, 0, 15'd0, 8'h00, 0, 0, 1, 16'd0},
      '{1, 8'h03, 0, 15'd0, 8'h00, 0, 0, 1, 16'd0},
      '{1, 8'h10, 1, 15'd0, 8'h10, 0, 0, 1, 16'd0},
      '{1, 8'h20, 1, 15'd1, 8'h20, 0, 0, 1, 16'd0},
      '{1, 8'h30, 1, 15'd2, 8'h30, 0, 0, 1, 16'd0},
      '{1, 8'h60, 0, 15'd3, 8'h00, 1, 0, 0, 16'd1},
      // bad checksum A5 02 01 02 FF: rollback to 3
      '{1, 8'hA5, 0, 15'd3, 8'h00, 0, 0, 1, 16'd1},
      '{1, 8'h02, 0, 15'd3, 8'h00, 0, 0, 1, 16'd1},
      '{1, 8'h01, 1, 15'd3, 8'h01, 0, 0, 1, 16'd1},
      '{1, 8'h02, 1, 15'd4, 8'h02, 0, 0, 1, 16'd1},
      '{1, 8'hFF, 0, 15'd3, 8'h00, 0, 1, 0, 16'd1},
      // junk then zero length
      '{1, 8'h00, 0, 15'd3, 8'h00, 0, 0, 0, 16'd1},
      '{1, 8'h55, 0, 15'd3, 8'h00, 0, 0, 0, 16'd1},
      '{1, 8'hA5, 0, 15'd3, 8'h00, 0, 0, 1, 16'd1},
      '{1, 8'h00, 0, 15'd3, 8'h00, 0, 1, 0, 16'd1},
      '{0, 8'h00, 0, 15'd3, 8'h00, 0, 0, 0, 16'd1},
      // HDR value inside the frame is plain data: A5 02 A5 A5 4A
      '{1, 8'hA5, 0, 15'd3, 8'h00, 0, 0, 1, 16'd1},
      '{1, 8'h02, 0, 15'd3, 8'h00, 0, 0, 1, 16'd1},
      '{1, 8'hA5, 1, 15'd3, 8'hA5, 0, 0, 1, 16'd1},
      '{1, 8'hA5, 1, 15'd4, 8'hA5, 0, 0, 1, 16'd1},
      '{1, 8'h4A, 0, 15'd5, 8'h00, 1, 0, 0, 16'd2}
    };

    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst_n    = 1'b0;
    step(0, 8'h00);
    step(0, 8'h00);
    check_outs("reset", '{0, 8'h00, 0, 15'd0, 8'h00, 0, 0, 0, 16'd0});
    check("reset.wr_data", wr_data, 8'h00);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d);
      check_outs($sformatf("vec%0d", i), vecs[i]);
    end

    // Timeout: err exactly T cycles after the last byte, pointer back to 5.
    step(1, 8'hA5);
    step(1, 8'h04);
    step(1, 8'h11);
    check_outs("to_wr", '{0, 8'h00, 1, 15'd5, 8'h11, 0, 0, 1, 16'd2});
    for (int i = 1; i < int'(T); i++) begin
      step(0, 8'h00);
      if (frame_err !== 1'b0 || busy !== 1'b1)
        check($sformatf("to_early%0d", i), {frame_err, busy}, 2'b01);
    end
    step(0, 8'h00);
    check_outs("to_fire", '{0, 8'h00, 0, 15'd5, 8'h00, 0, 1, 0, 16'd2});
    step(0, 8'h00);
    check("to_pulse_end", frame_err, 1'b0);

    // Byte on the expiry cycle wins.
    step(1, 8'hA5);
    step(1, 8'h01);
    for (int i = 1; i < int'(T); i++) step(0, 8'h00);
    step(1, 8'h77);
    check_outs("exp_byte", '{0, 8'h00, 1, 15'd5, 8'h77, 0, 0, 1, 16'd2});
    step(1, 8'h77);
    check_outs("exp_chk", '{0, 8'h00, 0, 15'd6, 8'h00, 1, 0, 0, 16'd3});

    // Advance the pointer from 6 to 7FFE with 128x255 + 1x120 zero frames.
    for (int f = 0; f < 129; f++) begin
      automatic int len = (f < 128) ? 255 : 120;
      step(1, 8'hA5);
      step(1, 8'(len));
      for (int b = 0; b < len; b++) step(1, 8'h00);
      step(1, 8'h00);
    end
    check("fill.wr_addr", wr_addr, 15'h7FFE);
    check("fill.cnt", frame_cnt, 16'd132);

    // Pointer wrap: 7FFE, 7FFF, 0000.
    step(1, 8'hA5);
    step(1, 8'h03);
    step(1, 8'h01);
    check_outs("wrap0", '{0, 8'h00, 1, 15'h7FFE, 8'h01, 0, 0, 1, 16'd132});
    step(1, 8'h02);
    check_outs("wrap1", '{0, 8'h00, 1, 15'h7FFF, 8'h02, 0, 0, 1, 16'd132});
    step(1, 8'h03);
    check_outs("wrap2", '{0, 8'h00, 1, 15'h0000, 8'h03, 0, 0, 1, 16'd132});
    step(1, 8'h06);
    check_outs("wrap_chk", '{0, 8'h00, 0, 15'd1, 8'h00, 1, 0, 0, 16'd133});

    // Mid-frame reset: no err, everything back to reset values.
    step(1, 8'hA5);
    step(1, 8'h02);
    step(1, 8'hAA);
    check_outs("mr_wr", '{0, 8'h00, 1, 15'd1, 8'hAA, 0, 0, 1, 16'd133});
    rst_n = 1'b0;
    step(0, 8'h00);
    check_outs("mr_rst", '{0, 8'h00, 0, 15'd0, 8'h00, 0, 0, 0, 16'd0});
    check("mr_rst.wr_data", wr_data, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < int'(T) + 4; i++) begin
      step(0, 8'h00);
      if (frame_err !== 1'b0) check($sformatf("mr_noerr%0d", i), frame_err, 1'b0);
    end
    step(1, 8'hA5);
    step(1, 8'h01);
    step(1, 8'h5A);
    check_outs("mr_next_wr", '{0, 8'h00, 1, 15'd0, 8'h5A, 0, 0, 1, 16'd0});
    step(1, 8'h5A);
    check_outs("mr_next_chk", '{0, 8'h00, 0, 15'd1, 8'h00, 1, 0, 0, 16'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
